// File: rtl/time_set_editor_pkg.sv
// time_set_editor_pkg
//   Shared definitions for the button-driven time editor: field indices used
//   by the cursor, the power-on time, FSM/event encodings and the calendar
//   helper days_in_month().
package time_set_editor_pkg;

  // Cursor positions, in the order the left/right buttons walk them.
  localparam logic [2:0] FLD_YEAR  = 3'd0;
  localparam logic [2:0] FLD_MONTH = 3'd1;
  localparam logic [2:0] FLD_DAY   = 3'd2;
  localparam logic [2:0] FLD_HOUR  = 3'd3;
  localparam logic [2:0] FLD_MIN   = 3'd4;
  localparam logic [2:0] FLD_SEC   = 3'd5;
  localparam logic [2:0] FLD_WEEK  = 3'd6;

  // Committed time after reset: 2000-01-01 00:00:00, Saturday.
  localparam logic [14:0] RST_YEAR  = 15'd2000;
  localparam logic [3:0]  RST_MONTH = 4'd1;
  localparam logic [4:0]  RST_DAY   = 5'd1;
  localparam logic [5:0]  RST_HOUR  = 6'd0;
  localparam logic [5:0]  RST_MIN   = 6'd0;
  localparam logic [5:0]  RST_SEC   = 6'd0;
  localparam logic [3:0]  RST_WEEK  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // The single button event that is acted on in a given cycle.
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_MIDDLE = 3'd1,
    EV_UP     = 3'd2,
    EV_DOWN   = 3'd3,
    EV_LEFT   = 3'd4,
    EV_RIGHT  = 3'd5
  } event_t;

  // Days in a month; every year divisible by 4 is a leap year (exact for 2000-2099).
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [14:0] year);
    logic [4:0] d;
    case (month)
      4'd2:                    d = (year % 15'd4 == 15'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/time_set_editor_btn_debounce.sv
// btn_debounce
//   One front-panel button: 2-FF synchronizer, debounce counter and press
//   pulse. The synchronized level must differ from the accepted level for
//   DEBOUNCE_CYCLES+1 consecutive samples before it is accepted; a one-cycle
//   press pulse is emitted on an accepted 0->1 change only.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (button treated as released)
//   btn       raw asynchronous active-high button
//   press     one-cycle press event
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync_p0;
  logic        sync_p1;
  logic        stable;
  logic [19:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // any sample agreeing with the accepted level restarts the count
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES) begin
        stable <= sync_p1;
        cnt    <= '0;
        press  <= sync_p1;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// time_set_editor
//   Writer side of the clock's time-setting interface. Middle enters edit
//   with a snapshot of the live time, left/right move the cursor, up/down
//   step the field under the cursor with wrap, middle again commits the
//   edited time with a one-cycle load strobe. Idle edits time out silently.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   up, down, left, right, middle     raw buttons (asynchronous, active-high)
//   cur_year..cur_week                live time, sampled on edit entry
//   year_d..sec_d, week_s             committed time (registered)
//   load                              one-cycle strobe, clock core adopts *_d
//   editing                           high while editing
//   cursor                            field under edit (FLD_YEAR..FLD_WEEK)
module time_set_editor
  import time_set_editor_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000000,
  parameter int          YEAR_MIN        = 2000,
  parameter int          YEAR_MAX        = 2099
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic [14:0] cur_year,
  input  logic [3:0]  cur_month,
  input  logic [4:0]  cur_day,
  input  logic [5:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  input  logic [3:0]  cur_week,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic        load,
  output logic        editing,
  output logic [2:0]  cursor
);

  localparam logic [14:0] YEAR_LO = 15'(YEAR_MIN);
  localparam logic [14:0] YEAR_HI = 15'(YEAR_MAX);

  // Step v by +/-1 inside [lo, hi]; out-of-range values land on the far end.
  function automatic logic [14:0] wrap_step(input logic [14:0] v, input logic [14:0] lo,
                                            input logic [14:0] hi, input logic inc);
    if (inc) return (v >= hi) ? lo : v + 15'd1;
    return (v <= lo) ? hi : v - 15'd1;
  endfunction

  logic ev_mid, ev_up, ev_dn, ev_lt, ev_rt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mid (.clk(clk), .rst(rst), .btn(middle), .press(ev_mid));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up  (.clk(clk), .rst(rst), .btn(up),     .press(ev_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn  (.clk(clk), .rst(rst), .btn(down),   .press(ev_dn));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lt  (.clk(clk), .rst(rst), .btn(left),   .press(ev_lt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rt  (.clk(clk), .rst(rst), .btn(right),  .press(ev_rt));

  event_t ev;

  always_comb begin
    ev = EV_NONE;
    if      (ev_mid) ev = EV_MIDDLE;
    else if (ev_up)  ev = EV_UP;
    else if (ev_dn)  ev = EV_DOWN;
    else if (ev_lt)  ev = EV_LEFT;
    else if (ev_rt)  ev = EV_RIGHT;
  end

  state_t      state, state_nxt;
  logic [31:0] to_cnt;
  logic        to_hit;

  assign to_hit = (to_cnt >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    editing   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev == EV_MIDDLE) state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        editing = 1'b1;
        if (ev == EV_MIDDLE)                 state_nxt = ST_COMMIT;
        else if (ev == EV_NONE && to_hit)    state_nxt = ST_IDLE;
      end
      ST_COMMIT: begin
        load      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counts consecutive event-free cycles in EDIT; zero everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   to_cnt <= '0;
    else if (state != ST_EDIT || ev != EV_NONE) to_cnt <= '0;
    else if (!to_hit)                          to_cnt <= to_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor <= FLD_YEAR;
    end else if (state == ST_IDLE && ev == EV_MIDDLE) begin
      cursor <= FLD_YEAR;
    end else if (state == ST_EDIT && ev == EV_LEFT) begin
      cursor <= (cursor == FLD_YEAR) ? FLD_WEEK : cursor - 3'd1;
    end else if (state == ST_EDIT && ev == EV_RIGHT) begin
      cursor <= (cursor >= FLD_WEEK) ? FLD_YEAR : cursor + 3'd1;
    end
  end

  logic [14:0] e_year,  e_year_n;
  logic [3:0]  e_month, e_month_n;
  logic [4:0]  e_day,   e_day_n;
  logic [5:0]  e_hour,  e_hour_n;
  logic [5:0]  e_min,   e_min_n;
  logic [5:0]  e_sec,   e_sec_n;
  logic [3:0]  e_week,  e_week_n;
  logic        inc;
  logic [4:0]  dim_cur;
  logic [4:0]  dim_new;

  assign inc     = (ev == EV_UP);
  assign dim_cur = days_in_month(e_month, e_year);

  always_comb begin
    e_year_n  = e_year;
    e_month_n = e_month;
    e_day_n   = e_day;
    e_hour_n  = e_hour;
    e_min_n   = e_min;
    e_sec_n   = e_sec;
    e_week_n  = e_week;
    dim_new   = dim_cur;
    if (state == ST_IDLE && ev == EV_MIDDLE) begin
      e_year_n  = cur_year;
      e_month_n = cur_month;
      e_day_n   = cur_day;
      e_hour_n  = cur_hour;
      e_min_n   = cur_min;
      e_sec_n   = cur_sec;
      e_week_n  = cur_week;
    end else if (state == ST_EDIT && (ev == EV_UP || ev == EV_DOWN)) begin
      case (cursor)
        FLD_YEAR:  e_year_n  = wrap_step(e_year, YEAR_LO, YEAR_HI, inc);
        FLD_MONTH: e_month_n = 4'(wrap_step({11'd0, e_month}, 15'd1, 15'd12, inc));
        FLD_DAY:   e_day_n   = 5'(wrap_step({10'd0, e_day}, 15'd1, {10'd0, dim_cur}, inc));
        FLD_HOUR:  e_hour_n  = 6'(wrap_step({9'd0, e_hour}, 15'd0, 15'd23, inc));
        FLD_MIN:   e_min_n   = 6'(wrap_step({9'd0, e_min}, 15'd0, 15'd59, inc));
        FLD_SEC:   e_sec_n   = 6'(wrap_step({9'd0, e_sec}, 15'd0, 15'd59, inc));
        FLD_WEEK:  e_week_n  = 4'(wrap_step({11'd0, e_week}, 15'd0, 15'd6, inc));
        default: ;
      endcase
      // a year/month step can shrink the month under the day (e.g. Feb 29 -> 2025)
      dim_new = days_in_month(e_month_n, e_year_n);
      if ((cursor == FLD_YEAR || cursor == FLD_MONTH) && e_day_n > dim_new) e_day_n = dim_new;
    end
  end

  // Edit registers are pure data: always loaded from cur_* before use.
  always_ff @(posedge clk) begin
    e_year  <= e_year_n;
    e_month <= e_month_n;
    e_day   <= e_day_n;
    e_hour  <= e_hour_n;
    e_min   <= e_min_n;
    e_sec   <= e_sec_n;
    e_week  <= e_week_n;
  end

  // Outputs update on the edge that enters COMMIT, so they are valid with load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_d  <= RST_YEAR;
      month_d <= RST_MONTH;
      day_d   <= RST_DAY;
      hour_d  <= RST_HOUR;
      min_d   <= RST_MIN;
      sec_d   <= RST_SEC;
      week_s  <= RST_WEEK;
    end else if (state == ST_EDIT && ev == EV_MIDDLE) begin
      year_d  <= e_year;
      month_d <= e_month;
      day_d   <= e_day;
      hour_d  <= e_hour;
      min_d   <= e_min;
      sec_d   <= e_sec;
      week_s  <= e_week;
    end
  end

endmodule

// File: tb/tb_time_set_editor.sv
module tb_time_set_editor;

  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, left, right, middle;
  logic [14:0] cur_year;
  logic [3:0]  cur_month;
  logic [4:0]  cur_day;
  logic [5:0]  cur_hour, cur_min, cur_sec;
  logic [3:0]  cur_week;
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [3:0]  week_s;
  logic        load, editing;
  logic [2:0]  cursor;

  time_set_editor #(
    .DEBOUNCE_CYCLES(20'd4),
    .TIMEOUT_CYCLES (32'd200),
    .YEAR_MIN       (2000),
    .YEAR_MAX       (2099)
  ) dut (
    .clk(clk), .rst(rst),
    .up(up), .down(down), .left(left), .right(right), .middle(middle),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec), .cur_week(cur_week),
    .year_d(year_d), .month_d(month_d), .day_d(day_d),
    .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d), .week_s(week_s),
    .load(load), .editing(editing), .cursor(cursor)
  );

  always #5 clk = ~clk;

  localparam int B_MID = 0, B_UP = 1, B_DN = 2, B_LT = 3, B_RT = 4;

  int checks = 0;
  int errors = 0;

  // load strobe monitor
  int   load_cnt = 0;
  int   dbl_cnt  = 0;
  logic load_q   = 1'b0;
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      if (load_q) dbl_cnt++;
    end
    load_q = (load === 1'b1);
  end

  // reference model: calendar rules with plain arithmetic
  bit m_edit;
  int m_cur;
  int m_loads;
  int m_f[7];
  int m_d[7];
  int m_c[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dim_of(input int m, input int y);
    int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && y % 4 == 0) return 29;
    return tab[m-1];
  endfunction

  task automatic model_reset();
    m_edit = 0;
    m_cur  = 0;
    m_d    = '{2000, 1, 1, 0, 0, 0, 6};
  endtask

  task automatic model_step(input int dir);
    int dm;
    case (m_cur)
      0: m_f[0] = (m_f[0] - 2000 + dir + 100) % 100 + 2000;
      1: m_f[1] = (m_f[1] - 1 + dir + 12) % 12 + 1;
      2: begin
        dm = dim_of(m_f[1], m_f[0]);
        m_f[2] = (m_f[2] - 1 + dir + dm) % dm + 1;
      end
      3: m_f[3] = (m_f[3] + dir + 24) % 24;
      4: m_f[4] = (m_f[4] + dir + 60) % 60;
      5: m_f[5] = (m_f[5] + dir + 60) % 60;
      default: m_f[6] = (m_f[6] + dir + 7) % 7;
    endcase
    if (m_cur <= 1 && m_f[2] > dim_of(m_f[1], m_f[0])) m_f[2] = dim_of(m_f[1], m_f[0]);
  endtask

  task automatic model_apply(input int b);
    if (!m_edit) begin
      if (b == B_MID) begin
        m_edit = 1;
        m_f    = m_c;
        m_cur  = 0;
      end
    end else begin
      case (b)
        B_MID: begin m_d = m_f; m_loads++; m_edit = 0; end
        B_UP:  model_step(1);
        B_DN:  model_step(-1);
        B_LT:  m_cur = (m_cur + 6) % 7;
        default: m_cur = (m_cur + 1) % 7;
      endcase
    end
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input int w);
    m_c       = '{y, mo, d, h, mi, s, w};
    cur_year  = 15'(y);
    cur_month = 4'(mo);
    cur_day   = 5'(d);
    cur_hour  = 6'(h);
    cur_min   = 6'(mi);
    cur_sec   = 6'(s);
    cur_week  = 4'(w);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MID: middle = v;
      B_UP:  up     = v;
      B_DN:  down   = v;
      B_LT:  left   = v;
      default: right = v;
    endcase
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".editing"}, {31'd0, editing}, m_edit);
    chk({tag, ".cursor"},  {29'd0, cursor},  m_cur);
    chk({tag, ".loads"},   load_cnt,         m_loads);
    chk({tag, ".year"},    {17'd0, year_d},  m_d[0]);
    chk({tag, ".month"},   {28'd0, month_d}, m_d[1]);
    chk({tag, ".day"},     {27'd0, day_d},   m_d[2]);
    chk({tag, ".hour"},    {26'd0, hour_d},  m_d[3]);
    chk({tag, ".min"},     {26'd0, min_d},   m_d[4]);
    chk({tag, ".sec"},     {26'd0, sec_d},   m_d[5]);
    chk({tag, ".week"},    {28'd0, week_s},  m_d[6]);
  endtask

  task automatic press(input int b, input string tag);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (12) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (12) @(negedge clk);
    model_apply(b);
    chk_all(tag);
  endtask

  task automatic press_n(input int b, input int n, input string tag);
    for (int i = 0; i < n; i++) press(b, tag);
  endtask

  initial begin
    int b, y, mo;
    rst = 1'b1;
    {up, down, left, right, middle} = '0;
    set_cur(2024, 2, 29, 13, 5, 59, 4);
    m_loads = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_load", {31'd0, load}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset");

    // month wraps through 12 back to 2, then day 29 -> 1, commit
    press(B_MID, "enter");
    press(B_RT, "cur_month");
    press_n(B_UP, 12, "month_up");
    press(B_RT, "cur_day");
    press(B_UP, "day_wrap");
    press(B_MID, "commit1");

    // year step clamps Feb 29 -> 28
    press(B_MID, "enter2");
    press(B_UP, "year_up");
    press(B_MID, "commit_clamp");

    // year wrap both ways
    set_cur(2099, 2, 29, 1, 2, 3, 0);
    press(B_MID, "enter3");
    press(B_UP, "year_2099_up");
    press(B_MID, "commit_yhi");
    set_cur(2000, 2, 29, 1, 2, 3, 0);
    press(B_MID, "enter4");
    press(B_DN, "year_2000_dn");
    press(B_MID, "commit_ylo");

    // hour/min wrap, cursor wrap
    set_cur(2010, 7, 15, 23, 0, 30, 2);
    press(B_MID, "enter5");
    press_n(B_RT, 3, "to_hour");
    press(B_UP, "hour_wrap");
    press(B_RT, "to_min");
    press(B_DN, "min_wrap");
    press(B_MID, "commit_hm");
    press(B_MID, "enter6");
    press(B_LT, "cursor_lt_wrap");
    press(B_RT, "cursor_rt_wrap");
    press(B_MID, "commit6");

    // simultaneous middle + up: only the commit happens
    set_cur(2050, 5, 10, 8, 9, 10, 3);
    press(B_MID, "enter7");
    @(negedge clk);
    middle = 1'b1;
    up     = 1'b1;
    repeat (12) @(negedge clk);
    middle = 1'b0;
    up     = 1'b0;
    repeat (12) @(negedge clk);
    model_apply(B_MID);
    chk_all("mid_up_same");
    chk("no_dbl_load", dbl_cnt, 0);

    // 2-cycle glitch on up is filtered out
    press(B_MID, "enter8");
    @(negedge clk);
    up = 1'b1;
    repeat (2) @(negedge clk);
    up = 1'b0;
    repeat (20) @(negedge clk);
    chk_all("glitch");
    press(B_MID, "commit_glitch");

    // timeout abandons the edit without loading
    press(B_MID, "enter9");
    press_n(B_RT, 4, "to_min9");
    press(B_UP, "min_up9");
    repeat (250) @(negedge clk);
    m_edit = 0;
    chk_all("timeout");

    // asynchronous reset mid-edit
    press(B_MID, "enter10");
    press(B_RT, "cur10");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst_mid");
    chk("rst_mid_load", {31'd0, load}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    press(B_MID, "reenter");
    press(B_MID, "commit_reenter");

    // randomized sessions against the model
    for (int i = 0; i < 80; i++) begin
      if (!m_edit) begin
        y  = $urandom_range(2099, 2000);
        mo = $urandom_range(12, 1);
        set_cur(y, mo, $urandom_range(dim_of(mo, y), 1), $urandom_range(23, 0),
                $urandom_range(59, 0), $urandom_range(59, 0), $urandom_range(6, 0));
        press(B_MID, "rnd_enter");
      end else begin
        b = ($urandom_range(9, 0) == 0) ? B_MID : $urandom_range(4, 1);
        press(b, "rnd");
      end
    end
    if (m_edit) press(B_MID, "rnd_final");
    chk("no_dbl_load_end", dbl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
